// File: rtl/mem_access_pkg.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : mem_access_pkg
// Brief    : LSU opcodes, access FSM states and lane-offset width helper.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
package mem_access_pkg;

    typedef enum logic [3:0] {
        LSU_LB  = 4'b0000,
        LSU_LH  = 4'b0001,
        LSU_LW  = 4'b0010,
        LSU_LBU = 4'b1000,
        LSU_LHU = 4'b1001,
        LSU_SB  = 4'b0100,
        LSU_SH  = 4'b0101,
        LSU_SW  = 4'b0110
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Number of address bits that select a byte lane within one bus beat.
    function automatic int OFF_W(input int bus_w);
        return (bus_w == 64) ? 3 : 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : lsu_align
// Brief    : Combinational opcode decode, store lane steering and load
//            extraction/extension for the memory access unit.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
module lsu_align
    import mem_access_pkg::*;
#(
    parameter  int BUS_W = 32,
    localparam int SW    = BUS_W / 8,
    localparam int OW    = OFF_W(BUS_W)
) (
    input  logic [3:0]       st_op,
    input  logic [OW-1:0]    st_off,
    input  logic [31:0]      st_wdata,
    output logic             is_mem,
    output logic             is_load,
    output logic             misalign,
    output logic [SW-1:0]    wstrb,
    output logic [BUS_W-1:0] wdata,
    input  logic [3:0]       ld_op,
    input  logic [OW-1:0]    ld_off,
    input  logic [BUS_W-1:0] rdata,
    output logic [31:0]      ld_data
);

    logic [SW-1:0] w_base;
    logic [31:0]   w_word;

    always_comb begin
        is_mem   = 1'b1;
        is_load  = 1'b0;
        misalign = 1'b0;
        w_base   = '0;
        case (st_op)
            LSU_LB, LSU_LBU: is_load = 1'b1;
            LSU_LH, LSU_LHU: begin
                is_load  = 1'b1;
                misalign = st_off[0];
            end
            LSU_LW: begin
                is_load  = 1'b1;
                misalign = |st_off[1:0];
            end
            LSU_SB: w_base = SW'(4'h1);
            LSU_SH: begin
                w_base   = SW'(4'h3);
                misalign = st_off[0];
            end
            LSU_SW: begin
                w_base   = SW'(4'hF);
                misalign = |st_off[1:0];
            end
            default: is_mem = 1'b0;
        endcase
        wstrb = w_base << st_off;
        // Replicating the word lets every strobe width pick its bytes off the same shifted bus.
        wdata = {(BUS_W/32){st_wdata}} << {st_off, 3'b000};
    end

    always_comb begin
        w_word = 32'(rdata >> {ld_off, 3'b000});
        case (ld_op)
            LSU_LB:  ld_data = {{24{w_word[7]}}, w_word[7:0]};
            LSU_LBU: ld_data = {24'b0, w_word[7:0]};
            LSU_LH:  ld_data = {{16{w_word[15]}}, w_word[15:0]};
            LSU_LHU: ld_data = {16'b0, w_word[15:0]};
            default: ld_data = w_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : mem_access_unit
// Brief    : Pipeline memory stage: EX handshake in, single-beat bus access,
//            WB handshake out. MEM_ACCESS_MISALIGN_EXC_EN turns misaligned
//            accesses into flagged exceptions.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int BUS_W  = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_inst,
    input  logic [3:0]           in_lsu_op,
    input  logic [ADDR_W-1:0]    in_addr,
    input  logic [DATA_W-1:0]    in_wdata,
    input  logic                 in_rw_en,
    input  logic [4:0]           in_rw_addr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [31:0]          out_inst,
    output logic                 out_rw_en,
    output logic [4:0]           out_rw_addr,
    output logic [DATA_W-1:0]    out_rw_data,
    output logic                 out_excp,
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [ADDR_W-1:0]    bus_addr,
    output logic [BUS_W/8-1:0]   bus_wstrb,
    output logic [BUS_W-1:0]     bus_wdata,
    input  logic                 bus_gnt,
    input  logic                 bus_rvalid,
    input  logic [BUS_W-1:0]     bus_rdata
);

    localparam int SW = BUS_W / 8;
    localparam int OW = OFF_W(BUS_W);
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
    localparam bit MISALIGN_EXC = 1'b1;
`else
    localparam bit MISALIGN_EXC = 1'b0;
`endif

    state_e          r_state;
    logic [3:0]      r_op;
    logic [OW-1:0]   r_off;

    logic            w_is_mem;
    logic            w_is_load;
    logic            w_misalign;
    logic [SW-1:0]   w_wstrb;
    logic [BUS_W-1:0] w_wdata;
    logic [31:0]     w_ld_data;

    lsu_align #(.BUS_W(BUS_W)) u_align (
        .st_op    (in_lsu_op),
        .st_off   (in_addr[OW-1:0]),
        .st_wdata (in_wdata),
        .is_mem   (w_is_mem),
        .is_load  (w_is_load),
        .misalign (w_misalign),
        .wstrb    (w_wstrb),
        .wdata    (w_wdata),
        .ld_op    (r_op),
        .ld_off   (r_off),
        .rdata    (bus_rdata),
        .ld_data  (w_ld_data)
    );

    assign in_ready = (r_state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_off       <= '0;
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_inst    <= '0;
            out_rw_en   <= 1'b0;
            out_rw_addr <= '0;
            out_rw_data <= '0;
            out_excp    <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wstrb   <= '0;
            bus_wdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid) begin
                    r_op        <= in_lsu_op;
                    r_off       <= in_addr[OW-1:0];
                    out_pc      <= in_pc;
                    out_inst    <= in_inst;
                    out_rw_en   <= in_rw_en;
                    out_rw_addr <= in_rw_addr;
                    out_rw_data <= '0;
                    out_excp    <= 1'b0;
                    if (!w_is_mem) begin
                        out_rw_data <= DATA_W'(in_addr);
                        out_valid   <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (w_misalign) begin
                        // Misaligned access never reaches the bus; loads return zero.
                        out_valid <= 1'b1;
                        r_state   <= ST_DONE;
                        if (MISALIGN_EXC) begin
                            out_excp  <= 1'b1;
                            out_rw_en <= 1'b0;
                        end
                    end else begin
                        bus_req   <= 1'b1;
                        bus_we    <= !w_is_load;
                        bus_addr  <= {in_addr[ADDR_W-1:OW], {OW{1'b0}}};
                        bus_wstrb <= w_is_load ? '0 : w_wstrb;
                        bus_wdata <= w_is_load ? '0 : w_wdata;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: if (bus_gnt) begin
                    bus_req   <= 1'b0;
                    bus_we    <= 1'b0;
                    bus_wstrb <= '0;
                    if (bus_we) begin
                        out_valid <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: if (bus_rvalid) begin
                    out_rw_data <= w_ld_data;
                    out_valid   <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 32, meaning the byte-address width.
REQ-002 The block SHALL take parameter BUS_W, default 32 (legal 32 or 64), meaning the data-bus width; strobe width is BUS_W/8.
REQ-003 The block SHALL take parameter DATA_W, default 32, meaning the register width; it is fixed at 32.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid/in_ready  in/out  1  upstream (EX) handshake
- in_pc, in_inst  in  32  passthrough
- in_lsu_op  in  4  operation code
- in_addr  in  ADDR_W  effective address (EX result)
- in_wdata  in  32  store data
- in_rw_en, in_rw_addr  in  1, 5  register writeback passthrough
- out_valid/out_ready  out/in  1  downstream (WB) handshake
- out_pc, out_inst, out_rw_en, out_rw_addr  out  32, 32, 1, 5  registered passthrough
- out_rw_data  out  32  writeback data
- out_excp  out  1  misaligned-access flag
- bus_req, bus_we  out  1  bus request, write enable
- bus_addr  out  ADDR_W  BUS_W/8-aligned address
- bus_wstrb  out  BUS_W/8  byte strobes
- bus_wdata  out  BUS_W  lane-shifted store data
- bus_gnt  in  1  request accepted
- bus_rvalid, bus_rdata  in  1, BUS_W  read response

Function
REQ-005 Opcodes SHALL be: 0000 LD.B, 0001 LD.H, 0010 LD.W, 1000 LD.BU, 1001 LD.HU, 0100 ST.B, 0101 ST.H, 0110 ST.W; every other code is a non-memory op.
REQ-006 The FSM SHALL have the states IDLE, REQ, WAIT and DONE; in_ready is 1 only in IDLE, and a transfer occurs on in_valid&&in_ready.
REQ-007 On acceptance the block SHALL register all in_* fields; a non-memory op goes to DONE with out_rw_data=in_addr, so out_valid rises the next cycle.
REQ-008 A memory op SHALL go to REQ and hold bus_req=1 with stable bus_* until bus_gnt=1.
REQ-009 On bus_gnt, a store SHALL go to DONE and a load SHALL go to WAIT; bus_rvalid is accepted no earlier than the cycle after bus_gnt.
REQ-010 In WAIT, bus_rvalid=1 SHALL capture the load result and move to DONE.
REQ-011 In DONE, out_valid SHALL be 1 with all out_* stable until out_ready; the handshake returns to IDLE.
REQ-012 The minimum load latency SHALL be 3 cycles from acceptance to out_valid (gnt in the first REQ cycle, rvalid the next cycle); a store takes 2 cycles and a non-memory op takes 1.
REQ-013 Lane selection SHALL be off = in_addr[log2(BUS_W/8)-1:0], with bus_addr = in_addr with those bits cleared.
REQ-014 Store strobes SHALL be: B = 1<<off; H = 3<<off; W = 0xF<<off; bus_wdata = in_wdata replicated and shifted by off*8.
REQ-015 A load SHALL shift bus_rdata right by off*8; B and H sign-extend from bit 7 and bit 15 of the loaded data, and BU and HU zero-extend.
REQ-016 Alignment SHALL be: H requires addr[0]=0; W requires addr[1:0]=0.
REQ-017 bus_req SHALL never be asserted outside REQ.
REQ-018 Simultaneous out_ready and in_valid in DONE SHALL NOT accept new input that cycle, giving one bubble.

Reset
REQ-019 While rst_n=0, the state SHALL be IDLE, and out_valid, bus_req, bus_we, bus_wstrb, out_excp, out_rw_en and all data outputs SHALL be 0, with in_ready=1.
REQ-020 Reset asserted mid-transaction SHALL abandon it immediately; a later bus_rvalid in IDLE SHALL be ignored.

Configuration
REQ-021 With macro MEM_ACCESS_MISALIGN_EXC_EN defined, a misaligned op SHALL skip the bus and go directly to DONE with out_excp=1 and out_rw_en=0.
REQ-022 With MEM_ACCESS_MISALIGN_EXC_EN undefined, a misaligned store SHALL go to DONE with no bus access, and a misaligned load SHALL complete with out_rw_data=0; out_excp stays 0.

Structure
REQ-023 Package mem_access_pkg SHALL hold the lsu_op_e enum, the FSM state enum and the OFF_W function.
REQ-024 The combinational sub-module lsu_align SHALL hold the strobe, data-shift, extend and misalign logic.

Verification
REQ-025 The bench SHALL cover: LD.B with addr=0x1003, BUS_W=32, rdata=0x80FF_FF00 -> out_rw_data=0xFFFFFF80, out_valid 3 cycles after acceptance.
REQ-026 The bench SHALL cover: ST.H with addr=0x2002, wdata=0x0000_1234 -> bus_wstrb=1100, bus_wdata[31:16]=0x1234, bus_addr=0x2000.
REQ-027 The bench SHALL cover: BUS_W=64 LD.HU with addr=0x106, rdata=0xBEEF_0000_0000_0000 -> out_rw_data=0x0000BEEF.
REQ-028 The bench SHALL cover: bus_gnt held low for 5 cycles -> bus_req and bus_addr stable for all 5 cycles, in_ready=0.
REQ-029 The bench SHALL cover: LD.W with addr=0x3001 under MEM_ACCESS_MISALIGN_EXC_EN -> no bus_req, out_excp=1, out_rw_en=0.
REQ-030 The bench SHALL cover: rst_n pulsed low in WAIT, then bus_rvalid -> IDLE, out_valid=0, no output.
